// File: rtl/capture_window_ctrl_pkg.sv
// Shared types and Mac SE frame-buffer constants for the capture window controller.
package capture_window_ctrl_pkg;

   localparam int unsigned MAC_W              = 512;
   localparam int unsigned MAC_H              = 342;
   localparam int unsigned MAC_BYTES_PER_LINE = MAC_W / 8;
   localparam int unsigned FB_ADDR_W          = 15;
   localparam int unsigned CNT_W              = 12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [7:0]           data;
   } fb_wr_t;

   function automatic int unsigned frame_bytes(input int unsigned w, input int unsigned h);
      return (w * h) / 8;
   endfunction

endpackage

// File: rtl/capture_window_ctrl_if.sv
// Frame-buffer byte write port: transfer happens when fb_wr_en && fb_wr_ready.
interface capture_window_ctrl_if;
   import capture_window_ctrl_pkg::*;

   logic                 fb_wr_en;
   logic [FB_ADDR_W-1:0] fb_wr_addr;
   logic [7:0]           fb_wr_data;
   logic                 fb_wr_ready;

   modport master (output fb_wr_en, output fb_wr_addr, output fb_wr_data, input fb_wr_ready);
   modport slave  (input fb_wr_en, input fb_wr_addr, input fb_wr_data, output fb_wr_ready);

endinterface

// File: rtl/capture_window_ctrl_mono_byte_packer.sv
// Packs qualified mono samples MSB-first into bytes and drives the frame-buffer write handshake.
module mono_byte_packer
   import capture_window_ctrl_pkg::*;
#(
   parameter int unsigned INVERT      = 1,
   parameter int unsigned FRAME_BYTES = frame_bytes(MAC_W, MAC_H)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr_i,
   input  logic                          sample_i,
   input  logic                          mono_i,
   capture_window_ctrl_if.master         fb,
   output logic                          drop_c,
   output logic                          last_acc_c
);

   localparam logic                 INV_BIT   = 1'(INVERT);
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_BYTES - 1);

   logic [7:0]           sr_q;
   logic [2:0]           cnt_q;
   logic [FB_ADDR_W-1:0] addr_q;
   fb_wr_t               hold_q;
   logic                 wr_en_q;

   logic                 sample;
   logic                 byte_done;
   logic                 pending;
   logic [7:0]           new_byte;

   assign sample     = sample_i & ~clr_i;
   assign new_byte   = {sr_q[6:0], mono_i ^ INV_BIT};
   assign byte_done  = sample & (cnt_q == 3'd7);
   // A write accepted this cycle frees the holding register for the byte completing now.
   assign pending    = wr_en_q & ~fb.fb_wr_ready;
   assign drop_c     = byte_done & pending;
   assign last_acc_c = wr_en_q & fb.fb_wr_ready & (hold_q.addr == LAST_ADDR);

   // Shift register, bit count and next byte address; clr discards any partial byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
      end else if (clr_i) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
      end else if (sample) begin
         sr_q  <= new_byte;
         cnt_q <= cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            addr_q <= addr_q + FB_ADDR_W'(1);
         end
      end
   end

   // Holding register and write request; pending writes survive clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q  <= '0;
         wr_en_q <= 1'b0;
      end else if (byte_done && !pending) begin
         hold_q  <= '{addr: addr_q, data: new_byte};
         wr_en_q <= 1'b1;
      end else if (wr_en_q && fb.fb_wr_ready) begin
         wr_en_q <= 1'b0;
      end
   end

   assign fb.fb_wr_en   = wr_en_q;
   assign fb.fb_wr_addr = hold_q.addr;
   assign fb.fb_wr_data = hold_q.data;

endmodule

// File: rtl/capture_window_ctrl.sv
// Captures a mono window of TFP401 video into a byte-wide frame buffer; owns timing counters and FSM.
module capture_window_ctrl
   import capture_window_ctrl_pkg::*;
#(
   parameter int unsigned H_OFFSET = 0,
   parameter int unsigned V_OFFSET = 0,
   parameter int unsigned OUT_W    = MAC_W,
   parameter int unsigned OUT_H    = MAC_H,
   parameter int unsigned INVERT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture_en,
   input  logic                  de_in,
   input  logic                  vsync_in,
   output logic                  coord_valid,
   input  logic                  mono_in,
   capture_window_ctrl_if.master fb,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  frame_err,
   input  logic                  clear_status
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] x_cnt_q, y_cnt_q;
   logic [CNT_W-1:0] x_rel, y_rel;
   logic             de_q, vs_q, cv_q;
   logic             frame_done_q, overflow_q, frame_err_q;
   logic             vs_rise, de_fall, in_win;
   logic             frame_start, frame_abort;
   logic             pk_clr, drop, last_acc;

   assign vs_rise = vsync_in & ~vs_q;
   assign de_fall = de_q & ~de_in;

   // Unsigned wrap makes coordinates left of/above the window fail the range test.
   assign x_rel  = x_cnt_q - CNT_W'(H_OFFSET);
   assign y_rel  = y_cnt_q - CNT_W'(V_OFFSET);
   assign in_win = (x_rel < CNT_W'(OUT_W)) && (y_rel < CNT_W'(OUT_H));

   assign coord_valid = de_in & capture_en & (state_q == ST_CAPTURE) & in_win;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
         de_q    <= 1'b0;
         vs_q    <= 1'b0;
         cv_q    <= 1'b0;
      end else begin
         de_q <= de_in;
         vs_q <= vsync_in;
         cv_q <= coord_valid;
         if (de_in) begin
            x_cnt_q <= x_cnt_q + CNT_W'(1);
         end else if (de_fall) begin
            x_cnt_q <= '0;
         end
         if (vs_rise) begin
            y_cnt_q <= '0;
         end else if (de_fall) begin
            y_cnt_q <= y_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (capture_en) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (vs_rise) begin
               state_d     = ST_CAPTURE;
               frame_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (vs_rise) begin
               frame_start = 1'b1;
               frame_abort = 1'b1;
            end else if (last_acc) begin
               state_d = ST_ARMED;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!capture_en) begin
         state_d     = ST_IDLE;
         frame_start = 1'b0;
         frame_abort = 1'b0;
      end
   end

   // Sticky status: a set event beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_done_q <= (state_q == ST_CAPTURE) && (state_d == ST_ARMED);
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clear_status) begin
            overflow_q <= 1'b0;
         end
         if (frame_abort) begin
            frame_err_q <= 1'b1;
         end else if (clear_status) begin
            frame_err_q <= 1'b0;
         end
      end
   end

   assign pk_clr = ~capture_en | (state_q != ST_CAPTURE) | frame_start;

   mono_byte_packer #(
      .INVERT      (INVERT),
      .FRAME_BYTES (frame_bytes(OUT_W, OUT_H))
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (pk_clr),
      .sample_i   (cv_q),
      .mono_i     (mono_in),
      .fb         (fb),
      .drop_c     (drop),
      .last_acc_c (last_acc)
   );

   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/capture_window_ctrl.md
CAPTURE_WINDOW_CTRL -- requirements
Module: capture_window_ctrl

Interface
REQ-001 Parameter H_OFFSET, default 0: active-video pixels skipped at the start of each line before the capture window.
REQ-002 Parameter V_OFFSET, default 0: active lines skipped after vsync before the capture window.
REQ-003 Parameter OUT_W, default 512; OUT_H, default 342: capture window size in pixels; OUT_W SHALL be a multiple of 8.
REQ-004 Parameter INVERT, default 1: 1 stores mono_in inverted, so white becomes 0 (Mac convention: 1 = black).
REQ-005 clk  in  1  pixel clock (tfp401_pclk); one clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 capture_en  in  1  level; high arms capture.
REQ-008 de_in, vsync_in  in  1 each  TFP401 data-enable and vsync (vsync active-high).
REQ-009 coord_valid  out  1  enable to the RGB-to-mono converter, combinational, same cycle as the pixel's de_in.
REQ-010 mono_in  in  1  converter output; valid one clk after coord_valid.
REQ-011 fb_wr_en  out  1; fb_wr_addr  out  15; fb_wr_data  out  8; fb_wr_ready  in  1: frame-buffer byte write, transfer when en && ready.
REQ-012 frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.
REQ-013 overflow, frame_err  out  1 each  sticky status; clear_status  in  1 clears both.

Function
REQ-014 x_cnt SHALL count de_in-high cycles within a line and clear on the de_in falling edge; y_cnt SHALL increment on each de_in falling edge and clear on the vsync_in rising edge.
REQ-015 FSM states: IDLE, ARMED, CAPTURE. IDLE->ARMED when capture_en=1; ARMED->CAPTURE on the vsync_in rising edge; CAPTURE->ARMED after the last byte is accepted; any state->IDLE when capture_en=0.
REQ-016 coord_valid SHALL be de_in && state==CAPTURE && H_OFFSET<=x_cnt<H_OFFSET+OUT_W && V_OFFSET<=y_cnt<V_OFFSET+OUT_H.
REQ-017 A one-cycle delayed copy of coord_valid SHALL qualify sampling of mono_in (XOR INVERT) into an 8-bit shift register, first pixel in bit 7.
REQ-018 After 8 qualified samples, the byte SHALL load into the output holding register; fb_wr_en is asserted the next cycle and held until fb_wr_ready.
REQ-019 Byte address SHALL be (y_cnt-V_OFFSET)*(OUT_W/8)+(x_cnt-H_OFFSET)/8. It SHALL increment per completed byte, dropped or not, and start at 0 each frame.
REQ-020 If a byte completes while the holding register is still pending, the new byte SHALL be dropped, the pending write kept, and overflow set.
REQ-021 A vsync_in rising edge in CAPTURE before the last byte SHALL set frame_err and restart capture at address 0; frame_done is not pulsed.
REQ-022 frame_done SHALL pulse on the cycle after the acceptance of address OUT_W*OUT_H/8-1 (21887 at defaults).
REQ-023 capture_en=0 mid-frame SHALL stop coord_valid immediately and discard the partial byte; an already-pending write SHALL still complete.
REQ-024 clear_status coincident with a set event: the set wins.

Reset
REQ-025 Reset SHALL force state IDLE, all counters and the shift register to 0, and the outputs coord_valid, fb_wr_en, frame_done, overflow, frame_err, fb_wr_addr and fb_wr_data to 0.
REQ-026 Reset asserted mid-write SHALL abandon the write; the first frame after release starts at address 0.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef, the Mac SE defaults (512, 342, 64 bytes/line) and FB_ADDR_W=15.
REQ-028 One sub-module, mono_byte_packer (shift register, count, holding register, write handshake), SHALL be instantiated; the timing counters and FSM stay in the top.

Verification
REQ-029 Defaults, 640x480 input, fb_wr_ready=1, alternating white/black -> 21888 writes, addresses 0..21887, data 0x55, one frame_done.
REQ-030 H_OFFSET=64, V_OFFSET=69, all white -> coord_valid first high at x=64,y=69; all data 0x00; no writes outside the window.
REQ-031 fb_wr_ready held low 16 clk during line 0 -> first byte held and written once; overflow=1; addresses still end at 21887.
REQ-032 vsync_in edge at y=100 in CAPTURE -> frame_err=1, no frame_done, next write address 0.
REQ-033 capture_en dropped at x=300,y=10 with a pending write -> write completes; state IDLE; coord_valid=0 thereafter.
REQ-034 reset pulsed mid-frame -> all outputs 0 within the same cycle; recapture starts at address 0 after the next vsync edge.
